pc_sequencer: RTL and testbench

Program-flow controller for the 8-bit processor: owns the program counter and a hardware return-address stack, and executes the flow-control class of instructions (NEXT, JMP, CALL, RET, JZ, JNZ) on behalf of the control unit. The control unit presents one flow operation per instruction, gated by a valid/ready handshake. The sequencer produces the fetch address for the next FETCH cycle. Stack overflow, stack underflow and illegal operations drive the block into a sticky fault state that stops sequencing.

---
 rtl/pc_sequencer_pkg.sv | 14 +
 rtl/pc_sequencer_if.sv | 26 ++
 rtl/pc_sequencer_return_stack.sv | 32 +++
 rtl/pc_sequencer.sv | 76 +++++++
 tb/tb_pc_sequencer.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
// pc_seq_pkg: flow opcode and fault-code encodings plus the RUN/FAULT state type
package pc_seq_pkg;
  localparam logic [2:0] OP_NEXT = 3'd0;
  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_CALL = 3'd2;
  localparam logic [2:0] OP_RET  = 3'd3;
  localparam logic [2:0] OP_JZ   = 3'd4;
  localparam logic [2:0] OP_JNZ  = 3'd5;
  localparam logic [1:0] FC_NONE = 2'd0;
  localparam logic [1:0] FC_OVF  = 2'd1;
  localparam logic [1:0] FC_UDF  = 2'd2;
  localparam logic [1:0] FC_ILL  = 2'd3;
  typedef enum logic {ST_RUN, ST_FAULT} state_t;
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control-unit <-> sequencer bus (clear, step handshake, op/target/zero_flag in; pc/taken/depth/fault out)
interface pc_sequencer_if #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
);
  localparam int DW = $clog2(STACK_DEPTH + 1);
  logic              clear;
  logic              step_valid;
  logic              step_ready;
  logic [2:0]        op;
  logic [ADDR_W-1:0] target;
  logic              zero_flag;
  logic [ADDR_W-1:0] pc;
  logic              taken;
  logic [DW-1:0]     depth;
  logic              fault;
  logic [1:0]        fault_code;
  modport master (
    output clear, step_valid, op, target, zero_flag,
    input  step_ready, pc, taken, depth, fault, fault_code
  );
  modport slave (
    input  clear, step_valid, op, target, zero_flag,
    output step_ready, pc, taken, depth, fault, fault_code
  );
endinterface

// File: rtl/pc_sequencer_return_stack.sv
// return_stack: unguarded LIFO of return addresses (clock, reset, clr, push, pop, wdata -> rdata, depth, full, empty)
module return_stack #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4,
  localparam int DW         = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] wdata,
  output logic [ADDR_W-1:0] rdata,
  output logic [DW-1:0]     depth,
  output logic              full,
  output logic              empty
);
  localparam int AW = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
  logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
  logic [DW-1:0]     depth_q, depth_d, top;
  assign top     = depth_q - DW'(1);
  assign rdata   = mem_q[top[AW-1:0]];
  assign depth_d = clr ? '0 : push ? depth_q + DW'(1) : pop ? top : depth_q;
  assign depth   = depth_q;
  assign full    = depth_q == DW'(STACK_DEPTH);
  assign empty   = depth_q == '0;
  always_ff @(posedge clock or posedge reset)
    if (reset) depth_q <= '0;
    else depth_q <= depth_d;
  always_ff @(posedge clock)
    if (push && !clr) mem_q[depth_q[AW-1:0]] <= wdata;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: pc register, flow-op execution and sticky fault FSM (clock, reset, bus: pc_sequencer_if.slave)
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input logic           clock,
  input logic           reset,
  pc_sequencer_if.slave bus
);
  localparam int DW = $clog2(STACK_DEPTH + 1);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, rdata;
  logic              taken_q, taken_d, push, pop, full, empty, acc, jump;
  logic [1:0]        fc_q, fc_d, fc_new;
  logic [DW-1:0]     depth;
  assign pc_inc = pc_q + ADDR_W'(1);
  assign acc    = bus.step_valid && state_q == ST_RUN;
  assign fc_new = bus.op == OP_CALL && full ? FC_OVF :
                  bus.op == OP_RET && empty ? FC_UDF :
                  bus.op > OP_JNZ ? FC_ILL : FC_NONE;
  assign jump   = bus.op == OP_JMP || bus.op == OP_CALL || bus.op == OP_RET ||
                  (bus.op == OP_JZ && bus.zero_flag) || (bus.op == OP_JNZ && !bus.zero_flag);
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    taken_d = 1'b0;
    fc_d    = fc_q;
    push    = 1'b0;
    pop     = 1'b0;
    if (bus.clear) begin
      state_d = ST_RUN;
      pc_d    = '0;
      fc_d    = FC_NONE;
    end else if (acc && fc_new != FC_NONE) begin
      state_d = ST_FAULT;
      fc_d    = fc_new;
    end else if (acc) begin
      pc_d    = bus.op == OP_RET ? rdata : jump ? bus.target : pc_inc;
      taken_d = jump;
      push    = bus.op == OP_CALL;
      pop     = bus.op == OP_RET;
    end
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= ST_RUN;
      pc_q    <= '0;
      taken_q <= 1'b0;
      fc_q    <= FC_NONE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      taken_q <= taken_d;
      fc_q    <= fc_d;
    end
  return_stack #(.ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH)) u_stack (
    .clock (clock),
    .reset (reset),
    .clr   (bus.clear),
    .push  (push),
    .pop   (pop),
    .wdata (pc_inc),
    .rdata (rdata),
    .depth (depth),
    .full  (full),
    .empty (empty)
  );
  assign bus.step_ready = state_q == ST_RUN;
  assign bus.pc         = pc_q;
  assign bus.taken      = taken_q;
  assign bus.depth      = depth;
  assign bus.fault      = state_q == ST_FAULT;
  assign bus.fault_code = fc_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed flow-op vectors checked every cycle against a queue-based model plus literal expectations
module tb_pc_sequencer;
  import pc_seq_pkg::*;
  logic clock = 1'b0;
  logic reset = 1'b1;
  pc_sequencer_if #(.ADDR_W(8), .STACK_DEPTH(4)) bus ();
  pc_sequencer #(.ADDR_W(8), .STACK_DEPTH(4)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  int checks = 0;
  int errors = 0;
  logic [7:0] m_pc;
  logic [7:0] m_stk[$];
  logic       m_taken, m_fault;
  logic [1:0] m_code;
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic m_reset();
    m_pc = 8'h00;
    m_stk.delete();
    m_taken = 1'b0;
    m_fault = 1'b0;
    m_code = 2'd0;
  endtask
  task automatic m_trip(input logic [1:0] c);
    m_fault = 1'b1;
    m_code = c;
  endtask
  always @(negedge clock)
    if (!reset) begin
      chk("pc", bus.pc, m_pc);
      chk("taken", bus.taken, m_taken);
      chk("depth", bus.depth, m_stk.size());
      chk("fault", bus.fault, m_fault);
      chk("fault_code", bus.fault_code, m_code);
      chk("step_ready", bus.step_ready, !m_fault);
    end
  task automatic cyc(input logic v, input logic [2:0] o, input logic [7:0] t, input logic z, input logic c);
    bus.step_valid = v;
    bus.op = o;
    bus.target = t;
    bus.zero_flag = z;
    bus.clear = c;
    @(posedge clock);
    m_taken = 1'b0;
    if (c) begin
      m_pc = 8'h00;
      m_stk.delete();
      m_fault = 1'b0;
      m_code = 2'd0;
    end else if (v && !m_fault) begin
      case (o)
        OP_NEXT: m_pc = m_pc + 8'd1;
        OP_JMP: begin m_pc = t; m_taken = 1'b1; end
        OP_CALL:
          if (m_stk.size() == 4) m_trip(2'd1);
          else begin m_stk.push_back(m_pc + 8'd1); m_pc = t; m_taken = 1'b1; end
        OP_RET:
          if (m_stk.size() == 0) m_trip(2'd2);
          else begin m_pc = m_stk.pop_back(); m_taken = 1'b1; end
        OP_JZ:
          if (z) begin m_pc = t; m_taken = 1'b1; end
          else m_pc = m_pc + 8'd1;
        OP_JNZ:
          if (!z) begin m_pc = t; m_taken = 1'b1; end
          else m_pc = m_pc + 8'd1;
        default: m_trip(2'd3);
      endcase
    end
    #1;
  endtask
  initial begin
    bus.step_valid = 1'b0;
    bus.op = OP_NEXT;
    bus.target = 8'h00;
    bus.zero_flag = 1'b0;
    bus.clear = 1'b0;
    m_reset();
    #1;
    chk("rst_pc", bus.pc, 0);
    chk("rst_ready", bus.step_ready, 1);
    chk("rst_fault", bus.fault, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    cyc(1, OP_NEXT, 8'h00, 0, 0); chk("next1_pc", bus.pc, 8'h01);
    cyc(1, OP_NEXT, 8'h00, 0, 0); chk("next2_pc", bus.pc, 8'h02);
    cyc(1, OP_NEXT, 8'h00, 0, 0); chk("next3_pc", bus.pc, 8'h03); chk("next3_taken", bus.taken, 0);
    cyc(1, OP_JMP, 8'h05, 0, 0);  chk("jmp_pc", bus.pc, 8'h05);
    cyc(1, OP_JZ, 8'h40, 1, 0);   chk("jz_pc", bus.pc, 8'h40); chk("jz_taken", bus.taken, 1);
    cyc(1, OP_JNZ, 8'h10, 1, 0);  chk("jnz_pc", bus.pc, 8'h41); chk("jnz_taken", bus.taken, 0);
    cyc(0, OP_JMP, 8'h77, 0, 0);  chk("idle_pc", bus.pc, 8'h41);
    cyc(1, OP_JZ, 8'h70, 0, 0);   chk("jz_nt_pc", bus.pc, 8'h42);
    cyc(1, OP_JNZ, 8'h60, 0, 0);  chk("jnz_t_pc", bus.pc, 8'h60);
    cyc(1, OP_JMP, 8'h20, 0, 0);
    cyc(1, OP_CALL, 8'h80, 0, 0); chk("call1_pc", bus.pc, 8'h80); chk("call1_depth", bus.depth, 1);
    cyc(1, OP_CALL, 8'h90, 0, 0); chk("call2_depth", bus.depth, 2);
    cyc(1, OP_RET, 8'h00, 0, 0);  chk("ret1_pc", bus.pc, 8'h81);
    cyc(1, OP_RET, 8'h00, 0, 0);  chk("ret2_pc", bus.pc, 8'h21); chk("ret2_depth", bus.depth, 0);
    for (int i = 1; i <= 4; i++) cyc(1, OP_CALL, 8'(i), 0, 0);
    chk("full_depth", bus.depth, 4);
    cyc(1, OP_CALL, 8'h99, 0, 0);
    chk("ovf_code", bus.fault_code, 1); chk("ovf_ready", bus.step_ready, 0);
    chk("ovf_pc", bus.pc, 8'h04); chk("ovf_depth", bus.depth, 4);
    cyc(1, OP_NEXT, 8'h00, 0, 0); chk("fault_hold_pc", bus.pc, 8'h04);
    cyc(0, OP_NEXT, 8'h00, 0, 1); chk("clr_pc", bus.pc, 0); chk("clr_depth", bus.depth, 0); chk("clr_fault", bus.fault, 0);
    cyc(1, OP_RET, 8'h00, 0, 0);  chk("udf_code", bus.fault_code, 2);
    cyc(0, OP_NEXT, 8'h00, 0, 1);
    cyc(1, 3'd6, 8'h00, 0, 0);    chk("ill6_code", bus.fault_code, 3);
    cyc(0, OP_NEXT, 8'h00, 0, 1);
    cyc(1, 3'd7, 8'h00, 0, 0);    chk("ill7_code", bus.fault_code, 3);
    cyc(0, OP_NEXT, 8'h00, 0, 1);
    cyc(1, OP_JMP, 8'hFF, 0, 0);
    cyc(1, OP_NEXT, 8'h00, 0, 0); chk("wrap_pc", bus.pc, 8'h00);
    cyc(1, OP_JMP, 8'hFF, 0, 0);
    cyc(1, OP_CALL, 8'h50, 0, 0); chk("callff_pc", bus.pc, 8'h50);
    cyc(1, OP_RET, 8'h00, 0, 0);  chk("retff_pc", bus.pc, 8'h00); chk("retff_taken", bus.taken, 1);
    cyc(1, OP_JMP, 8'h10, 0, 0);
    cyc(1, OP_CALL, 8'h20, 0, 0);
    cyc(1, OP_CALL, 8'h33, 0, 0); chk("pre_rst_pc", bus.pc, 8'h33); chk("pre_rst_depth", bus.depth, 2);
    #2;
    reset = 1'b1;
    m_reset();
    #1;
    chk("async_pc", bus.pc, 0); chk("async_depth", bus.depth, 0);
    chk("async_taken", bus.taken, 0); chk("async_ready", bus.step_ready, 1);
    @(negedge clock);
    #1;
    reset = 1'b0;
    cyc(1, OP_CALL, 8'h55, 0, 1); chk("clrcall_depth", bus.depth, 0); chk("clrcall_pc", bus.pc, 0);
    cyc(1, OP_NEXT, 8'h00, 0, 0); chk("resume_pc", bus.pc, 8'h01);
    cyc(0, OP_NEXT, 8'h00, 0, 0);
    @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
